ps2_keystroke_generator: RTL and testbench

Parametrised PS/2 device-side keystroke generator for Verilator benches and on-chip self-test of the PS/2 receive path. It accepts key events through a valid/ready FIFO, expands each into the correct scan-code byte sequence (optional E0 prefix, optional F0 break prefix, code) and serialises each byte as an 11-bit PS/2 frame on ps2Clk/ps2Dat. It supports host inhibit with abort-and-resend and per-event parity-error injection. It replaces the single-byte, single-event keyboard stimulus in the raycaster benches.

---
 rtl/ps2_keystroke_generator.sv | 194 +++++++++++++++++++
 tb/tb_ps2_keystroke_generator.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keystroke_generator.sv
// PS/2 device-side keystroke generator: queues key events, expands each into its
// scan-code bytes (E0, F0, code) and serialises them as 11-bit PS/2 frames.
module ps2_keystroke_generator #(
    parameter int CLK_DIV    = 2500,
    parameter int GAP_CYCLES = 5000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clock50MHz,
    input  logic       reset,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [7:0] key_code,
    input  logic       key_ext,
    input  logic       key_release,
    input  logic       key_badParity,
    input  logic       hostInhibit,
    output logic       ps2Clk,
    output logic       ps2Dat,
    output logic       busy,
    output logic [7:0] abortCount
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int HALF_W = $clog2(CLK_DIV);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] LOW   = 3'd2;
    localparam logic [2:0] GAP   = 3'd3;
    localparam logic [2:0] ABORT = 3'd4;

    // Event FIFO: entry = {badParity, ext, release, code}
    logic [10:0]      fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [PTR_W:0]   fifoCount, countNext;
    logic             keyReady;
    logic             push, pop;
    logic [10:0]      headEntry;

    logic [2:0]        state;
    logic [HALF_W-1:0] halfCnt;
    logic [GAP_W-1:0]  gapCnt;
    logic [3:0]        bitIdx, bitNext;
    logic [1:0]        byteIdx, lastIdx;
    logic              resend;
    logic [7:0]        evCode;
    logic              evExt, evRel, evBad;
    logic [7:0]        curByte;
    logic              parity;
    logic [10:0]       frameBits;

    assign key_ready = keyReady;
    assign push      = key_valid && keyReady;
    assign pop       = (state == IDLE) && (fifoCount != '0) && !hostInhibit;
    assign headEntry = fifoMem[rdPtr];

    always_comb begin
        countNext = fifoCount;
        if (push && !pop)
            countNext = fifoCount + 1'b1;
        else if (!push && pop)
            countNext = fifoCount - 1'b1;
    end

    always_ff @(posedge clock50MHz) begin
        if (push)
            fifoMem[wrPtr] <= {key_badParity, key_ext, key_release, key_code};
    end

    always_ff @(posedge clock50MHz or posedge reset) begin
        if (reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            keyReady  <= 1'b1;
        end else begin
            if (push)
                wrPtr <= wrPtr + 1'b1;
            if (pop)
                rdPtr <= rdPtr + 1'b1;
            fifoCount <= countNext;
            keyReady  <= (countNext != FULL_CNT);
        end
    end

    // Byte selection within the event: E0 first, then F0, then the code itself
    always_comb begin
        curByte = evCode;
        if (evExt && byteIdx == 2'd0)
            curByte = 8'hE0;
        else if (evRel && byteIdx == {1'b0, evExt})
            curByte = 8'hF0;
    end

    assign lastIdx   = {1'b0, evExt} + {1'b0, evRel};
    assign parity    = ~(^curByte) ^ evBad;
    assign frameBits = {1'b1, parity, curByte, 1'b0};
    assign bitNext   = bitIdx + 4'd1;

    always_ff @(posedge clock50MHz or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ps2Clk     <= 1'b1;
            ps2Dat     <= 1'b1;
            busy       <= 1'b0;
            abortCount <= '0;
            halfCnt    <= '0;
            gapCnt     <= '0;
            bitIdx     <= '0;
            byteIdx    <= '0;
            resend     <= 1'b0;
            evCode     <= '0;
            evExt      <= 1'b0;
            evRel      <= 1'b0;
            evBad      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        {evBad, evExt, evRel, evCode} <= headEntry;
                        byteIdx <= '0;
                        bitIdx  <= '0;
                        halfCnt <= '0;
                        ps2Clk  <= 1'b1;
                        ps2Dat  <= 1'b0;
                        busy    <= 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP, LOW: begin
                    // Inhibit wins even on the final cycle of the stop bit
                    if (hostInhibit) begin
                        ps2Clk  <= 1'b1;
                        ps2Dat  <= 1'b1;
                        halfCnt <= '0;
                        if (abortCount != 8'hFF)
                            abortCount <= abortCount + 8'd1;
                        state   <= ABORT;
                    end else if (halfCnt != HALF_LAST) begin
                        halfCnt <= halfCnt + 1'b1;
                    end else if (state == SETUP) begin
                        halfCnt <= '0;
                        ps2Clk  <= 1'b0;
                        state   <= LOW;
                    end else begin
                        halfCnt <= '0;
                        ps2Clk  <= 1'b1;
                        if (bitIdx == 4'd10) begin
                            ps2Dat <= 1'b1;
                            gapCnt <= '0;
                            resend <= 1'b0;
                            state  <= GAP;
                        end else begin
                            bitIdx <= bitNext;
                            ps2Dat <= frameBits[bitNext];
                            state  <= SETUP;
                        end
                    end
                end
                ABORT: begin
                    if (!hostInhibit) begin
                        gapCnt <= '0;
                        resend <= 1'b1;
                        state  <= GAP;
                    end
                end
                GAP: begin
                    if (gapCnt != GAP_LAST) begin
                        gapCnt <= gapCnt + 1'b1;
                    end else if (!hostInhibit) begin
                        if (!resend && byteIdx == lastIdx) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            if (!resend)
                                byteIdx <= byteIdx + 2'd1;
                            bitIdx  <= '0;
                            halfCnt <= '0;
                            ps2Dat  <= 1'b0;
                            state   <= SETUP;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_keystroke_generator.sv
// Bench for ps2_keystroke_generator: directed scenarios plus random events,
// frames decoded off the wire and matched against a byte-level model.
module tb_ps2_keystroke_generator;

    localparam int CLK_DIV    = 4;
    localparam int GAP_CYCLES = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME_CYC  = 22 * CLK_DIV;
    localparam int BYTE_CYC   = FRAME_CYC + GAP_CYCLES;

    logic       clock50MHz = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       key_ext = 1'b0;
    logic       key_release = 1'b0;
    logic       key_badParity = 1'b0;
    logic       hostInhibit = 1'b0;
    logic       key_ready, ps2Clk, ps2Dat, busy;
    logic [7:0] abortCount;

    ps2_keystroke_generator #(
        .CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clock50MHz(clock50MHz), .reset(reset),
        .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
        .key_ext(key_ext), .key_release(key_release), .key_badParity(key_badParity),
        .hostInhibit(hostInhibit), .ps2Clk(ps2Clk), .ps2Dat(ps2Dat),
        .busy(busy), .abortCount(abortCount)
    );

    initial forever #5 clock50MHz = ~clock50MHz;

    int checks = 0, failures = 0, cyc = 0;
    logic [10:0] sbQ[$];

    int frameStarts = 0, abortsSeen = 0, dataViol = 0, busyStart = 0;
    int lastBusyLen = 0, lastStartCyc = 0, falls = 0;
    bit inFrame = 0, timingOk = 0;
    logic [10:0] rxBits = '0;
    logic prevClk = 1'b1, prevDat = 1'b1, prevBusy = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [10:0] frameOf(input logic [7:0] d, input logic bad);
        logic par;
        par = ~(^d) ^ bad;
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic modelPush(input logic [7:0] c, input logic e, input logic r, input logic b);
        if (e) sbQ.push_back(frameOf(8'hE0, b));
        if (r) sbQ.push_back(frameOf(8'hF0, b));
        sbQ.push_back(frameOf(c, b));
    endtask

    task automatic sendEvent(input logic [7:0] c, input logic e, input logic r, input logic b,
                             output int acc, output logic rdyAfter);
        int waitCyc;
        key_code = c; key_ext = e; key_release = r; key_badParity = b; key_valid = 1'b1;
        waitCyc = 0;
        while (!key_ready && waitCyc < 5000) begin @(negedge clock50MHz); waitCyc++; end
        if (!key_ready) check("acceptTimeout", 0, 1);
        @(posedge clock50MHz); #1;
        acc = cyc;
        rdyAfter = key_ready;
        @(negedge clock50MHz);
        key_valid = 1'b0;
    endtask

    task automatic waitDrain(input int limit);
        int n;
        n = 0;
        while ((sbQ.size() != 0 || busy) && n < limit) begin @(negedge clock50MHz); n++; end
        if (sbQ.size() != 0 || busy) check("drainTimeout", sbQ.size(), 0);
    endtask

    task automatic waitFall(input int k);
        int n;
        n = 0;
        while (!(inFrame && falls == k) && n < 2000) begin @(negedge clock50MHz); n++; end
        if (!(inFrame && falls == k)) check("fallTimeout", falls, k);
    endtask

    int acc[6];
    logic rdy[6];
    int dummyAcc, relEdge, s0, n;
    logic dummyRdy;
    logic pend;
    logic [7:0] pc;
    logic pe, pr, pb;

    initial begin
        fork
            forever begin @(posedge clock50MHz); cyc++; end
            // expected bytes enter the scoreboard on the accepting edge
            forever begin
                @(negedge clock50MHz); #2;
                pend = key_valid && key_ready && !reset;
                pc = key_code; pe = key_ext; pr = key_release; pb = key_badParity;
                @(posedge clock50MHz);
                if (pend) modelPush(pc, pe, pr, pb);
            end
            // wire monitor: decode frames, drop those cut by host inhibit
            forever begin
                @(posedge clock50MHz); #1;
                if (reset) begin
                    inFrame = 0; falls = 0; abortsSeen = 0;
                end else begin
                    if (!ps2Clk && ps2Dat != prevDat) dataViol++;
                    if (busy && !prevBusy) busyStart = cyc;
                    if (!busy && prevBusy) lastBusyLen = cyc - busyStart;
                    if (!inFrame) begin
                        if (ps2Clk && !ps2Dat) begin
                            inFrame = 1; falls = 0; timingOk = 1;
                            lastStartCyc = cyc; frameStarts++;
                        end
                    end else if (hostInhibit) begin
                        inFrame = 0; abortsSeen++;
                    end else if (prevClk && !ps2Clk) begin
                        if (falls < 11) rxBits[falls] = ps2Dat;
                        else timingOk = 0;
                        if (cyc != lastStartCyc + CLK_DIV + falls * 2 * CLK_DIV) timingOk = 0;
                        falls++;
                    end else if (!prevClk && ps2Clk && falls == 11) begin
                        inFrame = 0;
                        if (cyc != lastStartCyc + FRAME_CYC) timingOk = 0;
                        check("frameTiming", int'(timingOk), 1);
                        if (sbQ.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL frame: got unexpected frame 0x%0h, expected none (cycle %0d)", rxBits, cyc);
                        end else
                            check("frame", int'(rxBits), int'(sbQ.pop_front()));
                    end
                end
                prevClk = ps2Clk; prevDat = ps2Dat; prevBusy = reset ? 1'b0 : busy;
            end
            begin
                #600000;
                $display("FAIL watchdog: simulation exceeded time limit");
                $fatal(1);
            end
        join_none

        repeat (3) @(negedge clock50MHz);
        check("rstClk", ps2Clk, 1);
        check("rstDat", ps2Dat, 1);
        check("rstBusy", busy, 0);
        check("rstReady", key_ready, 1);
        check("rstAbort", abortCount, 0);
        reset = 1'b0;
        @(negedge clock50MHz);

        // single make code
        sendEvent(8'h1C, 0, 0, 0, dummyAcc, dummyRdy);
        waitDrain(2000);
        check("busyLen1", lastBusyLen, BYTE_CYC);

        // extended break: E0 F0 75
        sendEvent(8'h75, 1, 1, 0, dummyAcc, dummyRdy);
        waitDrain(2000);
        check("busyLen3", lastBusyLen, 3 * BYTE_CYC);

        // abort in bit 5 low half, then resend after gap
        sendEvent(8'h29, 0, 0, 0, dummyAcc, dummyRdy);
        waitFall(6);
        hostInhibit = 1'b1;
        @(posedge clock50MHz); #1;
        check("abortClk", ps2Clk, 1);
        check("abortDat", ps2Dat, 1);
        check("abortCount1", abortCount, 1);
        repeat (50) @(negedge clock50MHz);
        hostInhibit = 1'b0;
        relEdge = cyc + 1;
        s0 = frameStarts;
        n = 0;
        while (frameStarts == s0 && n < 500) begin @(negedge clock50MHz); n++; end
        check("resendGap", lastStartCyc - relEdge, GAP_CYCLES);
        waitDrain(2000);

        // parity-error injection
        sendEvent(8'h1C, 0, 0, 1, dummyAcc, dummyRdy);
        waitDrain(2000);

        // FIFO backpressure with valid held
        for (int i = 0; i < 6; i++) sendEvent(8'h10 + 8'(i), 0, 0, 0, acc[i], rdy[i]);
        check("fifoBurst", acc[4] - acc[0], 4);
        check("readyLowAfter5", rdy[4], 0);
        check("sixthAccept", acc[5] - acc[0], BYTE_CYC + 3);
        waitDrain(3000);

        // random events with random inhibit pulses
        for (int i = 0; i < 24; i++) begin
            sendEvent(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0), dummyAcc, dummyRdy);
            repeat ($urandom_range(0, 60)) @(negedge clock50MHz);
            if ($urandom_range(0, 2) == 0) begin
                hostInhibit = 1'b1;
                repeat ($urandom_range(1, 25)) @(negedge clock50MHz);
                hostInhibit = 1'b0;
            end
        end
        waitDrain(30000);
        check("abortTally", abortCount, abortsSeen);

        // reset in the middle of a frame
        sendEvent(8'h33, 0, 0, 0, dummyAcc, dummyRdy);
        sendEvent(8'h34, 0, 0, 0, dummyAcc, dummyRdy);
        waitFall(4);
        reset = 1'b1;
        #1;
        check("midRstClk", ps2Clk, 1);
        check("midRstDat", ps2Dat, 1);
        check("midRstReady", key_ready, 1);
        check("midRstBusy", busy, 0);
        check("midRstAbort", abortCount, 0);
        sbQ.delete();
        repeat (3) @(negedge clock50MHz);
        reset = 1'b0;
        s0 = frameStarts;
        repeat (300) @(negedge clock50MHz);
        check("noFrameAfterRst", frameStarts, s0);
        check("idleAfterRst", busy, 0);
        check("dataOnlyWhileClkHigh", dataViol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
